byte_stream_arbiter: RTL and testbench

BYTE_STREAM_ARBITER -- requirements
Module: byte_stream_arbiter

---
 rtl/byte_stream_arbiter.sv | 124 ++++++++++++
 tb/tb_byte_stream_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_stream_arbiter.sv
// Round-robin arbiter that merges NREQ byte streams onto one registered output channel.
// A requester keeps the channel from its first byte until its last byte is accepted.
module byte_stream_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [DW-1:0]             data_out,
  output logic                      valid,
  output logic                      last_out,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic            vld_q, vld_d;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [DW-1:0]   gnt_data;
  logic            slot_free;
  logic            in_xfer;

  // Search starts just after the last owner, so that owner gets lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!sel_found && req_valid[IW'((int'(ptr_q) + k) % NREQ)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q == IW'(k)) gnt_data = req_data[k*DW +: DW];
    end
  end

  assign slot_free = ~vld_q | out_ready;
  assign in_xfer   = (state_q == LOCK) & slot_free & req_valid[gnt_q];

  always_comb begin
    req_ready = '0;
    if (state_q == LOCK && slot_free) req_ready[gnt_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCK;
          gnt_d   = sel_idx;
        end
      end
      LOCK: begin
        if (in_xfer && req_last[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new byte may replace the one leaving in the same cycle, keeping the stream bubble-free.
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    vld_d  = vld_q;
    if (in_xfer) begin
      data_d = gnt_data;
      last_d = req_last[gnt_q];
      vld_d  = 1'b1;
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

  assign data_out = data_q;
  assign valid    = vld_q;
  assign last_out = last_q;
  assign grant_id = gnt_q;
  assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Bench for byte_stream_arbiter: directed scenarios, then randomized traffic checked by a
// per-requester scoreboard plus packet-atomicity and round-robin fairness rules.
module tb_byte_stream_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic [DW-1:0]       data_out;
  logic                valid;
  logic                last_out;
  logic                out_ready;
  logic [1:0]          grant_id;
  logic                busy;

  byte_stream_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .data_out(data_out), .valid(valid), .last_out(last_out), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Entries are {byte, last}; data bytes carry the requester id in their top two bits.
  logic [8:0] snd_q [NREQ][$];
  logic [8:0] exp_q [NREQ][$];
  int         done_q[$];
  bit         pending   [NREQ];
  int         pend_since[NREQ];
  logic [5:0] seq       [NREQ];
  bit         rand_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [7:0] d, input bit l);
    req_valid[k]         = v;
    req_data[k*DW +: DW] = d;
    req_last[k]          = l;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_outs", {busy, valid, last_out, data_out, grant_id, req_ready}, 0);
    step();
    reset = 1'b0;
  endtask

  function automatic int queued();
    int n = 0;
    for (int k = 0; k < NREQ; k++) n += snd_q[k].size() + exp_q[k].size();
    return n;
  endfunction

  task automatic run_random(input int ncyc, input bit gen);
    logic [8:0] e;
    int         len;
    for (int t = 0; t < ncyc; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (snd_q[k].size() == 0 && gen && $urandom_range(3) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            e = {2'(k), seq[k], (b == len - 1)};
            seq[k] = seq[k] + 6'd1;
            snd_q[k].push_back(e);
            exp_q[k].push_back(e);
          end
          pending[k]    = 1'b1;
          pend_since[k] = cyc;
        end
        if (snd_q[k].size() != 0) begin
          req_valid[k]         = pending[k] ? 1'b1 : ($urandom_range(3) != 0);
          req_data[k*DW +: DW] = snd_q[k][0][8:1];
          req_last[k]          = snd_q[k][0][0];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end
      out_ready = gen ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          e = snd_q[k].pop_front();
          pending[k] = 1'b0;
          if (e[0]) done_q.push_back(cyc);
        end
      end
      step();
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks arbitration rules.
  initial begin : monitor
    int         owner, prev_owner, prev_done, src, k;
    bit         in_pkt, viol, reached;
    logic [8:0] e;
    owner = 0; prev_owner = NREQ - 1; prev_done = -1; in_pkt = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rand_on) begin
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        chk("ready_stall", (valid && !out_ready) ? req_ready : '0, 0);
        if (valid && out_ready) begin
          src = int'(data_out[7:6]);
          if (exp_q[src].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h with no byte pending from requester %0d", data_out, src);
          end else begin
            e = exp_q[src].pop_front();
            chk("out_byte", {data_out, last_out}, e);
            if (in_pkt) begin
              chk("no_interleave", src, owner);
            end else begin
              viol = 1'b0;
              reached = 1'b0;
              for (int j = 1; j < NREQ; j++) begin
                k = (prev_owner + j) % NREQ;
                if (k == src) reached = 1'b1;
                if (!reached && pending[k] && pend_since[k] <= prev_done) viol = 1'b1;
              end
              chk("rr_order", viol, 0);
            end
            owner  = src;
            in_pkt = !last_out;
            if (last_out) begin
              prev_owner = src;
              if (done_q.size() > 0) prev_done = done_q.pop_front();
            end
          end
        end
      end
    end
  end

  initial begin : main
    for (int k = 0; k < NREQ; k++) begin
      pending[k] = 1'b0;
      pend_since[k] = 0;
      seq[k] = '0;
    end

    // Single packet from requester 2 with latency checks.
    do_reset();
    set_req(2, 1, 8'h11, 0);
    step();
    chk("pkt_grant", {busy, grant_id}, {1'b1, 2'd2});
    chk("pkt_no_early_valid", valid, 0);
    step();
    chk("pkt_b0", {valid, data_out, last_out}, {1'b1, 8'h11, 1'b0});
    set_req(2, 1, 8'h22, 0);
    step();
    chk("pkt_b1", {valid, data_out, last_out}, {1'b1, 8'h22, 1'b0});
    set_req(2, 1, 8'h33, 1);
    step();
    chk("pkt_b2", {valid, data_out, last_out}, {1'b1, 8'h33, 1'b1});
    chk("pkt_busy_low", busy, 0);
    set_req(2, 0, 8'h00, 0);
    step();
    chk("pkt_drained", valid, 0);

    // Round-robin with all requesters sending single-byte packets.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 8'hA0 + 8'(i), 1);
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n >= 2) begin
        chk("rr_valid", valid, (n % 2 == 0));
        if (n % 2 == 0) chk("rr_data", data_out, 32'hA0 + ((n / 2 - 1) % 4));
      end
    end
    req_valid = '0;

    // Backpressure during requester 1 packet.
    do_reset();
    set_req(1, 1, 8'h55, 0);
    step();
    step();
    set_req(1, 1, 8'h66, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold", {valid, data_out, req_ready[1]}, {1'b1, 8'h55, 1'b0});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0010);
    step();
    chk("bp_b1", {valid, data_out, last_out}, {1'b1, 8'h66, 1'b1});
    set_req(1, 0, 8'h00, 0);
    step();
    chk("bp_drained", valid, 0);

    // Granted requester stalls mid-packet while another waits.
    do_reset();
    set_req(0, 1, 8'h01, 0);
    set_req(3, 1, 8'h30, 1);
    step();
    chk("lock_grant0", {busy, grant_id}, {1'b1, 2'd0});
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_hold", {busy, grant_id}, {1'b1, 2'd0});
    end
    chk("lock_quiet", valid, 0);
    set_req(0, 1, 8'h02, 1);
    step();
    chk("lock_last", {valid, data_out, last_out, busy}, {1'b1, 8'h02, 1'b1, 1'b0});
    set_req(0, 0, 8'h00, 0);
    step();
    chk("lock_next_grant", {busy, grant_id}, {1'b1, 2'd3});
    step();
    chk("lock_next_byte", {valid, data_out, last_out}, {1'b1, 8'h30, 1'b1});
    req_valid = '0;

    // Reset in the middle of a packet.
    do_reset();
    set_req(1, 1, 8'h41, 0);
    step();
    step();
    set_req(1, 1, 8'h42, 0);
    step();
    set_req(1, 1, 8'h43, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_outs", {busy, valid, last_out, data_out, grant_id, req_ready}, 0);
    step();
    reset = 1'b0;
    set_req(1, 1, 8'h41, 0);
    set_req(2, 1, 8'h51, 0);
    step();
    chk("midrst_regrant", {busy, grant_id}, {1'b1, 2'd1});

    // Randomized traffic against the scoreboard, then drain.
    do_reset();
    rand_on = 1'b1;
    run_random(3000, 1'b1);
    for (int i = 0; i < 1000 && queued() != 0; i++) run_random(1, 1'b0);
    step();
    step();
    chk("drain_empty", queued(), 0);
    rand_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
